// File: rtl/adc_sample_packer.sv
// -----------------------------------------------------------------------------
// adc_sample_packer
//
// Captures NUM_CH parallel ADC channels and turns them into OUT_W-bit words.
// Each word packs up to P = OUT_W/ADC_W samples. Words are presented on a
// valid/ready interface through a single holding register. When a completed
// word finds that register occupied, the word is dropped and counted.
//
// Pipeline:
//   edge k   : sample select (ramp / channel / interleave), keep strobe
//   edge k+1 : offset-binary conversion, packing, output register update
//
// Ports:
//   clk        sample clock
//   rst        asynchronous active-high reset
//   sample_en  acquisition enable; its rising edge latches the configuration
//   mode       0 = test ramp, 1 = single channel, 2 = interleave (3 acts as 1)
//   ch_sel     channel for single-channel mode (out of range -> channel 0)
//   pack_en    1 = P samples per word, 0 = one zero-extended sample per word
//   signed_in  1 = input is two's complement; converted to offset binary
//   decim      keep one of every decim+1 sample slots
//   adc_data   channel c at bits [c*ADC_W +: ADC_W]
//   out_data   packed output word
//   out_ch     channel of the sample held in the word LSBs
//   out_valid  word available
//   out_ready  downstream accepts when out_valid & out_ready
//   overrun    sticky flag: at least one word was dropped
//   drop_cnt   saturating count of dropped words
// -----------------------------------------------------------------------------
module adc_sample_packer #(
    parameter int NUM_CH  = 2,
    parameter int ADC_W   = 8,
    parameter int OUT_W   = 16,
    parameter int DECIM_W = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample_en,
    input  logic [1:0]                mode,
    input  logic [CH_W-1:0]           ch_sel,
    input  logic                      pack_en,
    input  logic                      signed_in,
    input  logic [DECIM_W-1:0]        decim,
    input  logic [NUM_CH*ADC_W-1:0]   adc_data,
    output logic [OUT_W-1:0]          out_data,
    output logic [CH_W-1:0]           out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overrun,
    output logic [15:0]               drop_cnt
);

    localparam int P    = OUT_W / ADC_W;
    localparam int PC_W = (P > 1) ? $clog2(P) : 1;
    localparam logic [ADC_W-1:0] MSB_FLIP = ADC_W'(1) << (ADC_W - 1);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

    // Latched configuration and sequencing state
    logic                r_en_d;
    logic [1:0]          r_mode;
    logic [CH_W-1:0]     r_ch_sel;
    logic                r_pack;
    logic                r_signed;
    logic [DECIM_W-1:0]  r_decim;
    logic [DECIM_W-1:0]  r_dcnt;
    logic [ADC_W-1:0]    r_ramp;
    logic [CH_W-1:0]     r_idx;

    // Stage-1 registers (selected sample plus its attributes)
    logic                r_s1_vld;
    logic                r_s1_en;
    logic [ADC_W-1:0]    r_s1_data;
    logic [CH_W-1:0]     r_s1_ch;
    logic                r_s1_cvt;
    logic                r_s1_pack;

    // Packing state
    logic [PC_W-1:0]     r_pcnt;
    logic [OUT_W-1:0]    r_buf;
    logic [CH_W-1:0]     r_word_ch;

    // Output holding register and statistics
    logic [OUT_W-1:0]    r_out_data;
    logic [CH_W-1:0]     r_out_ch;
    logic                r_out_valid;
    logic                r_overrun;
    logic [15:0]         r_drop_cnt;

    logic                w_rise;
    logic [1:0]          w_mode_raw;
    logic [1:0]          w_mode;
    logic [CH_W-1:0]     w_ch_sel;
    logic                w_pack;
    logic                w_signed;
    logic [DECIM_W-1:0]  w_decim;
    logic                w_keep;
    logic                w_dcnt_wrap;
    logic [CH_W-1:0]     w_sel_ch;
    logic [ADC_W-1:0]    w_chan_data;
    logic [ADC_W-1:0]    w_sample;
    logic [ADC_W-1:0]    w_conv;
    logic [OUT_W-1:0]    w_word;
    logic [CH_W-1:0]     w_word_ch;
    logic                w_last;
    logic                w_done;
    logic                w_accept;
    logic                w_load;
    logic                w_drop;

    // The latch cycle itself already runs with the incoming configuration.
    assign w_rise      = sample_en & ~r_en_d;
    assign w_mode_raw  = w_rise ? mode      : r_mode;
    assign w_ch_sel    = w_rise ? ch_sel    : r_ch_sel;
    assign w_pack      = w_rise ? pack_en   : r_pack;
    assign w_signed    = w_rise ? signed_in : r_signed;
    assign w_decim     = w_rise ? decim     : r_decim;
    assign w_mode      = (w_mode_raw == 2'd3) ? 2'd1 : w_mode_raw;
    // dcnt is held at 0 while disabled, so the first enabled slot is kept.
    assign w_keep      = sample_en & (r_dcnt == {DECIM_W{1'b0}});
    assign w_dcnt_wrap = (r_dcnt >= w_decim);

    // Source channel selection and sample mux
    always_comb begin
        w_sel_ch    = {CH_W{1'b0}};
        w_chan_data = {ADC_W{1'b0}};
        case (w_mode)
            2'd0: w_sel_ch = {CH_W{1'b0}};
            2'd2: w_sel_ch = r_idx;
            default: begin
                if ({1'b0, w_ch_sel} < NUM_CH_L) begin
                    w_sel_ch = w_ch_sel;
                end else begin
                    w_sel_ch = {CH_W{1'b0}};
                end
            end
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == w_sel_ch) begin
                w_chan_data = adc_data[c*ADC_W +: ADC_W];
            end else begin
                w_chan_data = w_chan_data;
            end
        end
        if (w_mode == 2'd0) begin
            w_sample = r_ramp;
        end else begin
            w_sample = w_chan_data;
        end
    end

    // Config latch, slot counter, ramp/interleave sequencing and stage-1 capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en_d    <= 1'b0;
            r_mode    <= 2'd0;
            r_ch_sel  <= {CH_W{1'b0}};
            r_pack    <= 1'b0;
            r_signed  <= 1'b0;
            r_decim   <= {DECIM_W{1'b0}};
            r_dcnt    <= {DECIM_W{1'b0}};
            r_ramp    <= {ADC_W{1'b0}};
            r_idx     <= {CH_W{1'b0}};
            r_s1_vld  <= 1'b0;
            r_s1_en   <= 1'b0;
            r_s1_data <= {ADC_W{1'b0}};
            r_s1_ch   <= {CH_W{1'b0}};
            r_s1_cvt  <= 1'b0;
            r_s1_pack <= 1'b0;
        end else begin
            r_en_d <= sample_en;
            if (w_rise) begin
                r_mode   <= mode;
                r_ch_sel <= ch_sel;
                r_pack   <= pack_en;
                r_signed <= signed_in;
                r_decim  <= decim;
            end
            if (!sample_en) begin
                r_dcnt <= {DECIM_W{1'b0}};
                r_ramp <= {ADC_W{1'b0}};
                r_idx  <= {CH_W{1'b0}};
            end else begin
                r_dcnt <= w_dcnt_wrap ? {DECIM_W{1'b0}} : r_dcnt + DECIM_W'(1);
                if (w_keep && (w_mode == 2'd0)) begin
                    r_ramp <= r_ramp + ADC_W'(1);
                end
                if (w_keep && (w_mode == 2'd2)) begin
                    r_idx <= (r_idx == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : r_idx + CH_W'(1);
                end
            end
            r_s1_vld  <= w_keep;
            r_s1_en   <= sample_en;
            r_s1_data <= w_sample;
            r_s1_ch   <= w_sel_ch;
            // The ramp is already offset binary; only ADC samples are converted.
            r_s1_cvt  <= w_signed & (w_mode != 2'd0);
            r_s1_pack <= (P > 1) ? w_pack : 1'b0;
        end
    end

    assign w_conv = r_s1_cvt ? (r_s1_data ^ MSB_FLIP) : r_s1_data;
    assign w_last = (r_pcnt == PC_W'(P - 1));
    assign w_done = r_s1_vld & (~r_s1_pack | w_last);

    // Word assembly: the new sample goes into slot r_pcnt, earlier slots come
    // from the buffer, and later slots stay zero.
    always_comb begin
        w_word = {OUT_W{1'b0}};
        if (!r_s1_pack) begin
            w_word[ADC_W-1:0] = w_conv;
        end else begin
            for (int k = 0; k < P; k++) begin
                if (PC_W'(k) == r_pcnt) begin
                    w_word[k*ADC_W +: ADC_W] = w_conv;
                end else if (PC_W'(k) < r_pcnt) begin
                    w_word[k*ADC_W +: ADC_W] = r_buf[k*ADC_W +: ADC_W];
                end else begin
                    w_word[k*ADC_W +: ADC_W] = {ADC_W{1'b0}};
                end
            end
        end
        if (r_s1_pack && (r_pcnt != {PC_W{1'b0}})) begin
            w_word_ch = r_word_ch;
        end else begin
            w_word_ch = r_s1_ch;
        end
    end

    assign w_accept = r_out_valid & out_ready;
    assign w_load   = w_done & (~r_out_valid | w_accept);
    assign w_drop   = w_done & ~w_load;

    // Packing counter, output holding register and drop statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt      <= {PC_W{1'b0}};
            r_buf       <= {OUT_W{1'b0}};
            r_word_ch   <= {CH_W{1'b0}};
            r_out_data  <= {OUT_W{1'b0}};
            r_out_ch    <= {CH_W{1'b0}};
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_drop_cnt  <= 16'h0000;
        end else begin
            // The stage-1 enable trails sample_en by one edge, so a partial
            // word is discarded only after its last kept sample was packed.
            if (!r_s1_en) begin
                r_pcnt <= {PC_W{1'b0}};
            end else if (r_s1_vld && r_s1_pack) begin
                r_pcnt <= w_last ? {PC_W{1'b0}} : r_pcnt + PC_W'(1);
                r_buf  <= w_word;
                if (r_pcnt == {PC_W{1'b0}}) begin
                    r_word_ch <= r_s1_ch;
                end
            end

            if (w_load) begin
                r_out_data  <= w_word;
                r_out_ch    <= w_word_ch;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end

            if (w_rise) begin
                r_overrun  <= 1'b0;
                r_drop_cnt <= 16'h0000;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_adc_sample_packer.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_packer
//
// Directed scenarios followed by randomized segments. A reference model kept
// in the bench works on whole samples: a queue collects the samples of the
// current word, a one-deep "pending" slot carries a finished word to the next
// edge, and a single-entry output slot models the holding register.
// -----------------------------------------------------------------------------
module tb_adc_sample_packer;

    localparam int NUM_CH  = 2;
    localparam int ADC_W   = 8;
    localparam int OUT_W   = 16;
    localparam int DECIM_W = 16;
    localparam int P       = OUT_W / ADC_W;
    localparam int SMASK   = (1 << ADC_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    sample_en;
    logic [1:0]              mode;
    logic [0:0]              ch_sel;
    logic                    pack_en;
    logic                    signed_in;
    logic [DECIM_W-1:0]      decim;
    logic [NUM_CH*ADC_W-1:0] adc_data;
    logic [OUT_W-1:0]        out_data;
    logic [0:0]              out_ch;
    logic                    out_valid;
    logic                    out_ready;
    logic                    overrun;
    logic [15:0]             drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    adc_sample_packer #(
        .NUM_CH (NUM_CH),
        .ADC_W  (ADC_W),
        .OUT_W  (OUT_W),
        .DECIM_W(DECIM_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sample_en(sample_en),
        .mode     (mode),
        .ch_sel   (ch_sel),
        .pack_en  (pack_en),
        .signed_in(signed_in),
        .decim    (decim),
        .adc_data (adc_data),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun),
        .drop_cnt (drop_cnt)
    );

    // Reference model state
    int m_mode, m_chsel, m_pack, m_signed, m_decim;
    int m_dcnt, m_ramp, m_idx;
    bit m_en_prev;
    int pq[$];
    int pq_ch;
    bit m_pend;
    int m_pend_word, m_pend_ch;
    bit m_valid, m_ovr;
    int m_data, m_ch, m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_chsel = 0; m_pack = 0; m_signed = 0; m_decim = 0;
        m_dcnt = 0; m_ramp = 0; m_idx = 0; m_en_prev = 1'b0;
        pq.delete(); pq_ch = 0;
        m_pend = 1'b0; m_pend_word = 0; m_pend_ch = 0;
        m_valid = 1'b0; m_ovr = 1'b0; m_data = 0; m_ch = 0; m_drop = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs now applied.
    task automatic model_edge();
        int v, ch, eff_mode, word;
        if (rst) begin
            model_reset();
            return;
        end
        // A word finished on the previous edge reaches the holding slot now.
        if (m_valid && out_ready) m_valid = 1'b0;
        if (m_pend) begin
            if (!m_valid) begin
                m_valid = 1'b1;
                m_data  = m_pend_word;
                m_ch    = m_pend_ch;
            end else begin
                m_ovr = 1'b1;
                if (m_drop < 65535) m_drop = m_drop + 1;
            end
        end
        m_pend = 1'b0;

        if (sample_en && !m_en_prev) begin
            m_mode = int'(mode); m_chsel = int'(ch_sel); m_pack = int'(pack_en);
            m_signed = int'(signed_in); m_decim = int'(decim);
            m_ovr = 1'b0; m_drop = 0;
        end

        if (!sample_en) begin
            m_dcnt = 0; m_ramp = 0; m_idx = 0;
            pq.delete();
        end else begin
            if (m_dcnt == 0) begin
                eff_mode = (m_mode == 3) ? 1 : m_mode;
                if (eff_mode == 0) begin
                    ch = 0;
                    v = m_ramp;
                    m_ramp = (m_ramp + 1) % (1 << ADC_W);
                end else begin
                    if (eff_mode == 2) begin
                        ch = m_idx;
                        m_idx = (m_idx + 1) % NUM_CH;
                    end else begin
                        ch = (m_chsel < NUM_CH) ? m_chsel : 0;
                    end
                    v = int'(adc_data >> (ADC_W * ch)) & SMASK;
                    if (m_signed != 0) v = (v + (1 << (ADC_W - 1))) % (1 << ADC_W);
                end
                if (m_pack != 0 && P > 1) begin
                    if (pq.size() == 0) pq_ch = ch;
                    pq.push_back(v);
                    if (pq.size() == P) begin
                        word = 0;
                        for (int k = 0; k < P; k++) word = word + (pq[k] << (ADC_W * k));
                        m_pend = 1'b1; m_pend_word = word; m_pend_ch = pq_ch;
                        pq.delete();
                    end
                end else begin
                    m_pend = 1'b1; m_pend_word = v; m_pend_ch = ch;
                end
            end
            m_dcnt = (m_dcnt >= m_decim) ? 0 : m_dcnt + 1;
        end
        m_en_prev = sample_en;
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("overrun",   32'(overrun),   32'(m_ovr));
        chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
        if (m_valid) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_ch",   32'(out_ch),   32'(m_ch));
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b1; sample_en = 1'b0; mode = 2'd0; ch_sel = 1'b0;
        pack_en = 1'b0; signed_in = 1'b0; decim = 16'd0;
        adc_data = 16'h0000; out_ready = 1'b0;
        cyc(2);
        chk("reset_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Single channel with signed conversion
        mode = 2'd1; ch_sel = 1'b1; signed_in = 1'b1; pack_en = 1'b0;
        decim = 16'd0; out_ready = 1'b1; sample_en = 1'b1;
        adc_data = {8'h80, 8'h5A};
        cyc(1);
        chk("sig_lat", 32'(out_valid), 32'd0);
        adc_data = {8'h7F, 8'hA5};
        cyc(1);
        chk("sig_w0", 32'(out_data), 32'h0000);
        chk("sig_ch", 32'(out_ch), 32'd1);
        adc_data = {8'h00, 8'h33};
        cyc(1);
        chk("sig_w1", 32'(out_data), 32'h00FF);
        cyc(1);
        chk("sig_w2", 32'(out_data), 32'h0080);
        sample_en = 1'b0;
        cyc(3);

        // Test ramp, packed, with partial word discarded on disable
        mode = 2'd0; pack_en = 1'b1; signed_in = 1'b0; sample_en = 1'b1;
        cyc(3);
        chk("ramp_w0", 32'(out_data), 32'h0100);
        sample_en = 1'b0;
        cyc(4);
        sample_en = 1'b1;
        cyc(3);
        chk("ramp_restart", 32'(out_data), 32'h0100);
        cyc(6);
        sample_en = 1'b0;
        cyc(2);

        // Interleave, packed then unpacked
        mode = 2'd2; pack_en = 1'b1; adc_data = {8'h22, 8'h11}; sample_en = 1'b1;
        cyc(3);
        chk("il_pack", 32'(out_data), 32'h2211);
        cyc(2);
        chk("il_pack_ch", 32'(out_ch), 32'd0);
        sample_en = 1'b0;
        cyc(2);
        pack_en = 1'b0; sample_en = 1'b1;
        cyc(2);
        chk("il_w0", 32'(out_data), 32'h0011);
        cyc(1);
        chk("il_w1", 32'(out_data), 32'h0022);
        chk("il_w1_ch", 32'(out_ch), 32'd1);
        sample_en = 1'b0;
        cyc(2);

        // Decimation; a decim change while enabled must be ignored
        mode = 2'd1; ch_sel = 1'b0; decim = 16'd3; sample_en = 1'b1;
        cyc(2);
        decim = 16'd0;
        cyc(12);
        sample_en = 1'b0;
        cyc(2);

        // Backpressure and overrun
        decim = 16'd0; out_ready = 1'b0; sample_en = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            adc_data = {8'h00, 8'(v)};
            cyc(1);
        end
        sample_en = 1'b0;
        cyc(2);
        chk("bp_hold", 32'(out_data), 32'h0001);
        chk("bp_drops", 32'(drop_cnt), 32'd4);
        chk("bp_ovr", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        cyc(2);
        chk("bp_ovr_sticky", 32'(overrun), 32'd1);
        sample_en = 1'b1;
        cyc(1);
        chk("bp_ovr_clr", 32'(overrun), 32'd0);
        sample_en = 1'b0;
        cyc(3);

        // Asynchronous reset while a word is held with drop_cnt = 3
        out_ready = 1'b0; sample_en = 1'b1;
        cyc(4);
        sample_en = 1'b0;
        cyc(1);
        chk("pre_rst_drops", 32'(drop_cnt), 32'd3);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_drops", 32'(drop_cnt), 32'd0);
        check_outputs();
        cyc(2);
        rst = 1'b0;
        out_ready = 1'b1;
        cyc(3);

        // Randomized segments
        for (int seg = 0; seg < 40; seg++) begin
            mode = 2'($urandom_range(0, 3));
            ch_sel = 1'($urandom_range(0, 1));
            pack_en = 1'($urandom_range(0, 1));
            signed_in = 1'($urandom_range(0, 1));
            decim = 16'($urandom_range(0, 3));
            sample_en = 1'b1;
            for (int i = 0; i < int'($urandom_range(4, 30)); i++) begin
                adc_data = 16'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
                if (i == 2) begin
                    mode = 2'($urandom_range(0, 3));
                    decim = 16'($urandom_range(0, 3));
                    pack_en = ~pack_en;
                end
                cyc(1);
            end
            sample_en = 1'b0;
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
                out_ready = ($urandom_range(0, 1) != 0);
                cyc(1);
            end
            if ((seg % 13) == 5) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                check_outputs();
                cyc(1);
                rst = 1'b0;
            end
        end

        out_ready = 1'b1;
        cyc(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
